fetch_step1: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register of the 5-step pipeline. Holds the PC,

---
 rtl/fetch_step1.sv | 106 ++++++++++
 tb/tb_fetch_step1.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_step1.sv
// fetch_step1: instruction fetch with req/ready imem handshake, redirect/flush handling and IF/ID register
module fetch_step1 #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_mux_pc_branch_select,
    input  logic        i_stall,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_jump_target,
    input  logic        i_load_step1,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    output logic [31:0] o_instr_out,
    output logic [31:0] o_pc_out,
    output logic        o_instr_valid,
    output logic        o_flush_out
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_FLUSH} state_t;
    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_drain_addr;
    logic [31:0]   r_skid_instr;
    logic [31:0]   r_skid_pc;
    logic [31:0]   r_instr;
    logic [31:0]   r_pc_out;
    logic          r_valid;
    logic [CW-1:0] r_flush_cnt;
    logic [31:0]   w_redir_pc;
    logic [31:0]   w_pc_inc;
    always_comb begin
        w_redir_pc = (i_mux_pc_branch_select == 2'd1 ? i_branch_target :
                      i_mux_pc_branch_select == 2'd2 ? i_jump_target : r_pc) & ~32'h3;
    end
    assign w_pc_inc      = r_pc + 32'd4;
    assign o_imem_req    = rst_n && ((r_state == S_FETCH && i_load_step1) ||
                                     r_state == S_WAIT || r_state == S_DRAIN);
    assign o_imem_addr   = r_state == S_DRAIN ? r_drain_addr : r_pc;
    assign o_instr_out   = r_instr;
    assign o_pc_out      = r_pc_out;
    assign o_instr_valid = r_valid;
    assign o_flush_out   = r_flush_cnt != '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
            r_instr      <= NOP_INSTR;
            r_pc_out     <= '0;
            r_valid      <= 1'b0;
            r_flush_cnt  <= '0;
        end else if (i_stall) begin
            // an outstanding request still has to be retired before new fetches start
            r_pc         <= w_redir_pc;
            r_instr      <= NOP_INSTR;
            r_valid      <= 1'b0;
            r_flush_cnt  <= CW'(FLUSH_CYCLES);
            r_drain_addr <= o_imem_addr;
            r_state      <= ((r_state == S_WAIT || r_state == S_DRAIN) && !i_imem_ready) ? S_DRAIN : S_FLUSH;
        end else begin
            if (r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - CW'(1);
            if (i_load_step1) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
            case (r_state)
                S_FETCH, S_WAIT: begin
                    if (i_imem_ready && (i_load_step1 || r_state == S_WAIT)) begin
                        r_pc <= w_pc_inc;
                        if (i_load_step1) begin
                            r_instr  <= i_imem_rdata;
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_state  <= S_FETCH;
                        end else begin
                            r_skid_instr <= i_imem_rdata;
                            r_skid_pc    <= r_pc;
                            r_state      <= S_HOLD;
                        end
                    end else if (i_load_step1) r_state <= S_WAIT;
                end
                S_HOLD: begin
                    if (i_load_step1) begin
                        r_instr  <= r_skid_instr;
                        r_pc_out <= r_skid_pc;
                        r_valid  <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (i_imem_ready) r_state <= r_flush_cnt == '0 ? S_FETCH : S_FLUSH;
                end
                default: begin
                    if (r_flush_cnt <= CW'(1)) r_state <= S_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_step1.sv
// tb_fetch_step1: scoreboard bench for fetch_step1 with a table of redirect vectors and hand-written corner sequences
module tb_fetch_step1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        stall = 1'b0;
    logic [31:0] bt = '0;
    logic [31:0] jt = '0;
    logic        load = 1'b1;
    logic [31:0] rdata;
    logic        ready = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic [31:0] o_instr_out;
    logic [31:0] o_pc_out;
    logic        o_instr_valid;
    logic        o_flush_out;

    fetch_step1 dut (
        .clk(clk), .rst_n(rst_n), .i_mux_pc_branch_select(sel), .i_stall(stall),
        .i_branch_target(bt), .i_jump_target(jt), .i_load_step1(load),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_rdata(rdata),
        .i_imem_ready(ready), .o_instr_out(o_instr_out), .o_pc_out(o_pc_out),
        .o_instr_valid(o_instr_valid), .o_flush_out(o_flush_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] ad);
        return {~ad[15:0], ad[15:0]} ^ 32'h0F0F_0000;
    endfunction
    assign rdata = mem(o_imem_addr);

    typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
    typedef struct {logic [1:0] sel; logic [31:0] bt; logic [31:0] jt; logic [31:0] exp; logic keep;} vec_t;
    ent_t        sb[$];
    vec_t        vt[5];
    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] a = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: drive, check request side, push expected word, clock, pop on new IF/ID word
    task automatic tick(input logic ld, input logic rdy, input logic exp_req, input logic [31:0] ad, input logic push);
        ent_t e;
        load = ld;
        ready = rdy;
        #1;
        chk("imem_req", {31'd0, o_imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", o_imem_addr, ad);
        if (push) begin
            sb.push_back({mem(ad), ad});
            a = ad + 32'd4;
        end
        @(posedge clk);
        #1;
        if (ld && o_instr_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'd0, o_instr_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("instr_out", o_instr_out, e.instr);
                chk("pc_out", o_pc_out, e.pc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        logic [31:0] hold_instr;
        logic [31:0] hold_pc;
        int w;
        vt[0] = '{2'd1, 32'h0000_0040, 32'hDEAD_0000, 32'h0000_0040, 1'b0};
        vt[1] = '{2'd2, 32'h0000_5555, 32'h0000_0103, 32'h0000_0100, 1'b0};
        vt[2] = '{2'd0, 32'hAAAA_0000, 32'hBBBB_0000, 32'h0, 1'b1};
        vt[3] = '{2'd3, 32'h1111_0000, 32'h2222_0000, 32'h0, 1'b1};
        vt[4] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0010, 32'hFFFF_FFFC, 1'b0};

        load = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, o_imem_req}, 32'd0);
        chk("rst_instr", o_instr_out, 32'h0);
        chk("rst_pc_out", o_pc_out, 32'h0);
        chk("rst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("rst_flush", {31'd0, o_flush_out}, 32'd0);
        rst_n = 1'b1;

        // ready tied high: back-to-back fetches from RESET_PC
        a = 32'h0;
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b1, 1'b1, a, 1'b1);
        chk("stream_valid", {31'd0, o_instr_valid}, 32'd1);

        // three wait cycles then one response
        old = a;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1, old, 1'b0);
        chk("wait_bubble", {31'd0, o_instr_valid}, 32'd0);
        tick(1'b1, 1'b1, 1'b1, old, 1'b1);
        tick(1'b1, 1'b1, 1'b1, a, 1'b1);

        // response arrives while step 2 is frozen -> skid, then release
        tick(1'b1, 1'b0, 1'b1, a, 1'b0);
        hold_instr = o_instr_out;
        hold_pc = o_pc_out;
        tick(1'b0, 1'b1, 1'b1, a, 1'b1);
        chk("hold_instr", o_instr_out, hold_instr);
        chk("hold_pc", o_pc_out, hold_pc);
        tick(1'b0, 1'b1, 1'b0, a, 1'b0);
        tick(1'b0, 1'b1, 1'b0, a, 1'b0);
        chk("hold_instr2", o_instr_out, hold_instr);
        tick(1'b1, 1'b0, 1'b0, a, 1'b0);
        chk("skid_valid", {31'd0, o_instr_valid}, 32'd1);
        tick(1'b1, 1'b1, 1'b1, a, 1'b1);

        // redirect table, zero-wait memory
        foreach (vt[i]) begin
            sel = vt[i].sel;
            bt = vt[i].bt;
            jt = vt[i].jt;
            stall = 1'b1;
            load = 1'b1;
            ready = 1'b1;
            #1;
            chk("redir_req", {31'd0, o_imem_req}, 32'd1);
            @(posedge clk);
            #1;
            stall = 1'b0;
            if (!vt[i].keep) a = vt[i].exp;
            chk("redir_flush1", {31'd0, o_flush_out}, 32'd1);
            chk("redir_valid", {31'd0, o_instr_valid}, 32'd0);
            tick(1'b1, 1'b1, 1'b0, a, 1'b0);
            chk("redir_flush2", {31'd0, o_flush_out}, 32'd1);
            tick(1'b1, 1'b1, 1'b0, a, 1'b0);
            chk("redir_flush_end", {31'd0, o_flush_out}, 32'd0);
            tick(1'b1, 1'b1, 1'b1, a, 1'b1);
        end
        tick(1'b1, 1'b1, 1'b1, 32'h0, 1'b1);

        // redirect while a request is outstanding -> drain and discard
        old = a;
        tick(1'b1, 1'b0, 1'b1, old, 1'b0);
        sel = 2'd2;
        jt = 32'h0000_0200;
        stall = 1'b1;
        ready = 1'b0;
        #1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        chk("drain_flush", {31'd0, o_flush_out}, 32'd1);
        tick(1'b1, 1'b0, 1'b1, old, 1'b0);
        chk("drain_valid", {31'd0, o_instr_valid}, 32'd0);
        tick(1'b1, 1'b1, 1'b1, old, 1'b0);
        chk("drain_valid2", {31'd0, o_instr_valid}, 32'd0);
        load = 1'b1;
        ready = 1'b0;
        w = 0;
        while (!o_imem_req && w < 8) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_resume", {31'd0, o_imem_req}, 32'd1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0204, 1'b1);

        // reset in the middle of a wait abandons the request
        tick(1'b1, 1'b0, 1'b1, a, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, o_imem_req}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_valid", {31'd0, o_instr_valid}, 32'd0);
        chk("midrst_pc_out", o_pc_out, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 32'h4, 1'b1);

        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
